rtc_cmd_scheduler: RTL and testbench
====================================

Name: rtc_cmd_scheduler

Overview:
Sequences and shares the single DS1302 byte-transaction engine (`ds1302_module`) between three sources: a power-up init sequence, a periodic time poller, and a host set-time request port. It drives the engine's one-hot `Start_Sig` and write data, consumes `Done_Sig` and read data, and publishes a coherent hour/minute/second snapshot. It sits between the application logic and `ds1302_module`, replacing ad-hoc sequencing with arbitration, validation and a watchdog.

Parameters:
POLL_CYCLES, 12500000, clock cycles between poll ticks (4 Hz at 50 MHz); must be ≥ 2.
INIT_ENABLE, 1, 1 = run unprotect + time-set sequence after reset; 0 = only unprotect.
INIT_HOUR, 8'h12, BCD hour written at init (24 h mode).
INIT_MINUTE, 8'h22, BCD minute written at init.
INIT_SECOND, 8'h22, BCD second written at init.
TIMEOUT_CYCLES, 65535, maximum cycles `Start_Sig` may be held without `Done_Sig`.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RST  in  1  synchronous, active-high reset.
Set_Req  in  1  level; host requests a time set; held until Set_Ack.
Set_Hour  in  8  BCD hour, 00–23.
Set_Minute  in  8  BCD minute, 00–59.
Set_Second  in  8  BCD second, 00–59.
Set_Ack  out  1  1-cycle pulse; the request was accepted or rejected.
Set_Err  out  1  valid with Set_Ack; 1 = rejected (invalid BCD), no write performed.
Set_Done  out  1  1-cycle pulse when the set write sequence completes.
Time_Hour  out  8  last snapshot hour.
Time_Minute  out  8  last snapshot minute.
Time_Second  out  8  last snapshot second; bit 7 is always 0.
Time_Valid  out  1  1-cycle pulse when the snapshot updates.
Busy  out  1  1 whenever the FSM is not in IDLE.
Timeout_Err  out  1  1-cycle pulse on watchdog expiry.
Start_Sig  out  8  one-hot engine command: [7] write WP reg, [6] write hour, [5] write minute, [4] write second, [0] read second, [1] read minute, [2] read hour.
Time_Write_Data  out  8  engine write byte.
Done_Sig  in  1  engine 1-cycle completion pulse.
Time_Read_Data  in  8  engine read byte; valid when Done_Sig = 1.

Behaviour:
- Reset values:
  - Outputs: all 0, except `Busy` = 1.
  - FSM: INIT_WP.
  - Poll counter: 0; poll-pending flag: 0.
  - Watchdog: 0.
  - The top level must reset `ds1302_module` concurrently (tie `RSTn = ~RST`). Reset mid-transaction abandons the command; `Start_Sig` is 0 after the reset edge.
- Command step rules:
  - The FSM drives exactly one `Start_Sig` bit plus `Time_Write_Data`, held stable until `Done_Sig` is sampled high.
  - On that edge, `Start_Sig` goes to 0 and the step advances. The next command asserts one cycle later, so there is exactly one idle cycle between commands.
  - `Done_Sig` while `Start_Sig` = 0 is ignored.
- Write data values:
  - WP write: 8'h00.
  - Hour write: bit 7 forced to 0 (24 h mode).
  - Second write: bit 7 forced to 0 (CH = 0, oscillator running).
- FSM transitions:
  - INIT_WP → INIT_H → INIT_M → INIT_S → RD_S → RD_M → RD_H → IDLE.
  - If INIT_ENABLE = 0: INIT_WP → RD_S.
  - IDLE, Set_Req = 1: validate the inputs.
    - Valid: Set_Ack = 1 and Set_Err = 0 in the same cycle; capture the values; go to SET_WP → SET_H → SET_M → SET_S → RD_S (forced readback). Set_Done pulses on the cycle SET_S sees Done_Sig.
    - Invalid: Set_Ack = 1 and Set_Err = 1; stay IDLE. An invalid value is any nibble > 9, hour > 23, or minute/second > 59.
  - IDLE, poll pending and no Set_Req: clear pending, go to RD_S.
  - Set_Req while not in IDLE: not acknowledged until IDLE is reached.
  - Set_Req and poll pending together in IDLE: the set wins. The pending flag stays set; its readback clears it.
- Snapshot:
  - RD_S and RD_M store the read byte in shadow registers.
  - On RD_H's Done_Sig, all three `Time_*` outputs load together (second bit 7 masked) and Time_Valid pulses.
  - Outputs never show a mixed old/new snapshot.
- Poll timer:
  - Free-running from reset; wraps at POLL_CYCLES−1 and sets pending.
  - Pending is a single bit; ticks during a busy period collapse into one.
- Watchdog:
  - Counts cycles while `Start_Sig` ≠ 0; clears on each new command.
  - On reaching TIMEOUT_CYCLES: Start_Sig ← 0, Timeout_Err pulses, go to IDLE. The snapshot is not updated; a set in progress gives no Set_Done.
  - A timeout during INIT also goes to IDLE; there is no retry.
- Busy = 0 only in IDLE.

Test Plan:
- Reset release with an engine BFM (Done 40 cycles after Start) → Start_Sig sequence 80, 40, 20, 10, 01, 02, 04; write data 00, 12, 22, 22; BFM reads return 22/22/12 → Time_Hour = 12, Time_Minute = 22, Time_Second = 22 with a single Time_Valid; one idle cycle between commands.
- POLL_CYCLES = 1000: BFM seconds increment; in IDLE → a read burst every 1000 cycles; with BFM Done latency 1500, at most one pending burst and no back-to-back duplicate.
- In IDLE, Set_Req with 23/59/58 → Set_Ack, Set_Err = 0; writes 00, 23, 59, 58; Set_Done; then readback with Time_Valid. Set_Req with hour 8'h24 or second 8'h5A → Set_Ack, Set_Err = 1, no Start_Sig.
- Set_Req raised during a poll read and a poll tick in the same IDLE cycle → read finishes; the set is acknowledged first; the forced readback clears pending; exactly one readback.
- BFM read second returns 8'hA5 → Time_Second = 8'h25.
- TIMEOUT_CYCLES = 100, BFM never responds during RD_M → Start_Sig drops after 100 cycles; Timeout_Err pulses; IDLE; Time_* unchanged. RST asserted mid-SET_H → next cycle Start_Sig = 0, INIT restarts, no Set_Done.

Source files
------------

// File: rtl/rtc_cmd_scheduler_if.sv
// Byte-transaction bus between the scheduler (master) and the DS1302 engine (slave).
interface rtc_cmd_scheduler_if;
   logic [7:0] Start_Sig;
   logic [7:0] Time_Write_Data;
   logic       Done_Sig;
   logic [7:0] Time_Read_Data;

   modport master (
      output Start_Sig,
      output Time_Write_Data,
      input  Done_Sig,
      input  Time_Read_Data
   );

   modport slave (
      input  Start_Sig,
      input  Time_Write_Data,
      output Done_Sig,
      output Time_Read_Data
   );
endinterface

// File: rtl/rtc_cmd_scheduler.sv
// Shares one DS1302 byte engine between power-up init, periodic polling and host
// set-time requests; publishes a coherent h/m/s snapshot and guards each command with a watchdog.
module rtc_cmd_scheduler #(
   parameter int unsigned POLL_CYCLES    = 12500000,
   parameter bit          INIT_ENABLE    = 1'b1,
   parameter logic [7:0]  INIT_HOUR      = 8'h12,
   parameter logic [7:0]  INIT_MINUTE    = 8'h22,
   parameter logic [7:0]  INIT_SECOND    = 8'h22,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Set_Req,
   input  logic [7:0] Set_Hour,
   input  logic [7:0] Set_Minute,
   input  logic [7:0] Set_Second,
   output logic       Set_Ack,
   output logic       Set_Err,
   output logic       Set_Done,
   output logic [7:0] Time_Hour,
   output logic [7:0] Time_Minute,
   output logic [7:0] Time_Second,
   output logic       Time_Valid,
   output logic       Busy,
   output logic       Timeout_Err,
   rtc_cmd_scheduler_if.master eng
);

   localparam int PC_W = $clog2(POLL_CYCLES);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_INIT_WP = 4'd1;
   localparam logic [3:0] ST_INIT_H  = 4'd2;
   localparam logic [3:0] ST_INIT_M  = 4'd3;
   localparam logic [3:0] ST_INIT_S  = 4'd4;
   localparam logic [3:0] ST_RD_S    = 4'd5;
   localparam logic [3:0] ST_RD_M    = 4'd6;
   localparam logic [3:0] ST_RD_H    = 4'd7;
   localparam logic [3:0] ST_SET_WP  = 4'd8;
   localparam logic [3:0] ST_SET_H   = 4'd9;
   localparam logic [3:0] ST_SET_M   = 4'd10;
   localparam logic [3:0] ST_SET_S   = 4'd11;

   function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max_v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
   endfunction

   logic [3:0]      state_r, state_nxt_s;
   logic [7:0]      start_r, start_nxt_s;
   logic [7:0]      wdata_r, wdata_nxt_s;
   logic [WD_W-1:0] wd_r, wd_nxt_s;
   logic [PC_W-1:0] poll_cnt_r, poll_cnt_nxt_s;
   logic            pend_r, pend_nxt_s, pend_clr_s, poll_tick_s;
   logic            ack_r, ack_nxt_s, err_r, err_nxt_s, done_r, done_nxt_s;
   logic            valid_r, valid_nxt_s, tmo_r, tmo_nxt_s, busy_r;
   logic [7:0]      hour_r, hour_nxt_s, min_r, min_nxt_s, sec_r, sec_nxt_s;
   logic [7:0]      sh_sec_r, sh_sec_nxt_s, sh_min_r, sh_min_nxt_s;
   logic [7:0]      cap_h_r, cap_h_nxt_s, cap_m_r, cap_m_nxt_s, cap_s_r, cap_s_nxt_s;
   logic [7:0]      cmd_start_s, cmd_data_s;
   logic [3:0]      cmd_next_s;
   logic            set_ok_s;

   assign set_ok_s = bcd_in_range(Set_Hour, 8'h23) && bcd_in_range(Set_Minute, 8'h59)
                  && bcd_in_range(Set_Second, 8'h59);

   // Command table: engine strobe, write byte and successor for each step state
   always_comb begin
      cmd_start_s = 8'h00;
      cmd_data_s  = 8'h00;
      cmd_next_s  = ST_IDLE;
      case (state_r)
         ST_INIT_WP: begin cmd_start_s = 8'h80; cmd_next_s = INIT_ENABLE ? ST_INIT_H : ST_RD_S; end
         ST_INIT_H:  begin cmd_start_s = 8'h40; cmd_data_s = INIT_HOUR & 8'h7F;   cmd_next_s = ST_INIT_M; end
         ST_INIT_M:  begin cmd_start_s = 8'h20; cmd_data_s = INIT_MINUTE;         cmd_next_s = ST_INIT_S; end
         ST_INIT_S:  begin cmd_start_s = 8'h10; cmd_data_s = INIT_SECOND & 8'h7F; cmd_next_s = ST_RD_S; end
         ST_RD_S:    begin cmd_start_s = 8'h01; cmd_next_s = ST_RD_M; end
         ST_RD_M:    begin cmd_start_s = 8'h02; cmd_next_s = ST_RD_H; end
         ST_RD_H:    begin cmd_start_s = 8'h04; cmd_next_s = ST_IDLE; end
         ST_SET_WP:  begin cmd_start_s = 8'h80; cmd_next_s = ST_SET_H; end
         ST_SET_H:   begin cmd_start_s = 8'h40; cmd_data_s = cap_h_r & 8'h7F; cmd_next_s = ST_SET_M; end
         ST_SET_M:   begin cmd_start_s = 8'h20; cmd_data_s = cap_m_r;         cmd_next_s = ST_SET_S; end
         ST_SET_S:   begin cmd_start_s = 8'h10; cmd_data_s = cap_s_r & 8'h7F; cmd_next_s = ST_RD_S; end
         default:    begin cmd_start_s = 8'h00; cmd_next_s = ST_IDLE; end
      endcase
   end

   // Sequencer: arbitration in IDLE, command issue / completion / watchdog otherwise
   always_comb begin
      state_nxt_s  = state_r;
      start_nxt_s  = start_r;
      wdata_nxt_s  = wdata_r;
      wd_nxt_s     = wd_r;
      ack_nxt_s    = 1'b0;
      err_nxt_s    = 1'b0;
      done_nxt_s   = 1'b0;
      valid_nxt_s  = 1'b0;
      tmo_nxt_s    = 1'b0;
      pend_clr_s   = 1'b0;
      hour_nxt_s   = hour_r;
      min_nxt_s    = min_r;
      sec_nxt_s    = sec_r;
      sh_sec_nxt_s = sh_sec_r;
      sh_min_nxt_s = sh_min_r;
      cap_h_nxt_s  = cap_h_r;
      cap_m_nxt_s  = cap_m_r;
      cap_s_nxt_s  = cap_s_r;
      if (state_r == ST_IDLE) begin
         // ack_r blocks a second acknowledge while the host is still dropping a rejected request
         if (Set_Req && !ack_r) begin
            ack_nxt_s = 1'b1;
            if (set_ok_s) begin
               cap_h_nxt_s = Set_Hour;
               cap_m_nxt_s = Set_Minute;
               cap_s_nxt_s = Set_Second;
               state_nxt_s = ST_SET_WP;
            end else begin
               err_nxt_s = 1'b1;
            end
         end else if (pend_r) begin
            pend_clr_s  = 1'b1;
            state_nxt_s = ST_RD_S;
         end else begin
            state_nxt_s = ST_IDLE;
         end
      end else if (start_r == 8'h00) begin
         start_nxt_s = cmd_start_s;
         wdata_nxt_s = cmd_data_s;
         wd_nxt_s    = {WD_W{1'b0}};
      end else if (eng.Done_Sig) begin
         start_nxt_s = 8'h00;
         state_nxt_s = cmd_next_s;
         case (state_r)
            ST_RD_S: sh_sec_nxt_s = eng.Time_Read_Data;
            ST_RD_M: sh_min_nxt_s = eng.Time_Read_Data;
            ST_RD_H: begin
               hour_nxt_s  = eng.Time_Read_Data;
               min_nxt_s   = sh_min_r;
               sec_nxt_s   = sh_sec_r & 8'h7F;
               valid_nxt_s = 1'b1;
            end
            ST_SET_S: begin
               done_nxt_s = 1'b1;
               pend_clr_s = 1'b1;
            end
            default: pend_clr_s = 1'b0;
         endcase
      end else if (wd_r == WD_LAST) begin
         start_nxt_s = 8'h00;
         tmo_nxt_s   = 1'b1;
         state_nxt_s = ST_IDLE;
      end else begin
         wd_nxt_s = wd_r + {{(WD_W-1){1'b0}}, 1'b1};
      end
   end

   // Free-running poll timer; a tick outranks a same-cycle clear so no tick is lost
   always_comb begin
      poll_tick_s = (poll_cnt_r == POLL_LAST);
      if (poll_tick_s) begin
         poll_cnt_nxt_s = {PC_W{1'b0}};
         pend_nxt_s     = 1'b1;
      end else begin
         poll_cnt_nxt_s = poll_cnt_r + {{(PC_W-1){1'b0}}, 1'b1};
         pend_nxt_s     = pend_r & ~pend_clr_s;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= ST_INIT_WP;
         start_r    <= 8'h00;
         wdata_r    <= 8'h00;
         wd_r       <= {WD_W{1'b0}};
         poll_cnt_r <= {PC_W{1'b0}};
         pend_r     <= 1'b0;
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
         done_r     <= 1'b0;
         valid_r    <= 1'b0;
         tmo_r      <= 1'b0;
         busy_r     <= 1'b1;
         hour_r     <= 8'h00;
         min_r      <= 8'h00;
         sec_r      <= 8'h00;
         sh_sec_r   <= 8'h00;
         sh_min_r   <= 8'h00;
         cap_h_r    <= 8'h00;
         cap_m_r    <= 8'h00;
         cap_s_r    <= 8'h00;
      end else begin
         state_r    <= state_nxt_s;
         start_r    <= start_nxt_s;
         wdata_r    <= wdata_nxt_s;
         wd_r       <= wd_nxt_s;
         poll_cnt_r <= poll_cnt_nxt_s;
         pend_r     <= pend_nxt_s;
         ack_r      <= ack_nxt_s;
         err_r      <= err_nxt_s;
         done_r     <= done_nxt_s;
         valid_r    <= valid_nxt_s;
         tmo_r      <= tmo_nxt_s;
         busy_r     <= (state_nxt_s != ST_IDLE);
         hour_r     <= hour_nxt_s;
         min_r      <= min_nxt_s;
         sec_r      <= sec_nxt_s;
         sh_sec_r   <= sh_sec_nxt_s;
         sh_min_r   <= sh_min_nxt_s;
         cap_h_r    <= cap_h_nxt_s;
         cap_m_r    <= cap_m_nxt_s;
         cap_s_r    <= cap_s_nxt_s;
      end
   end

   assign eng.Start_Sig       = start_r;
   assign eng.Time_Write_Data = wdata_r;
   assign Set_Ack     = ack_r;
   assign Set_Err     = err_r;
   assign Set_Done    = done_r;
   assign Time_Hour   = hour_r;
   assign Time_Minute = min_r;
   assign Time_Second = sec_r;
   assign Time_Valid  = valid_r;
   assign Busy        = busy_r;
   assign Timeout_Err = tmo_r;

endmodule

// File: tb/tb_rtc_cmd_scheduler.sv
// Scheduler bench: engine BFM plus a command/snapshot scoreboard checked by a negedge monitor.
module tb_rtc_cmd_scheduler;
   localparam int POLL     = 1000;
   localparam int TMO      = 100;
   localparam int BFM_LAT  = 40;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Set_Req = 1'b0;
   logic [7:0] Set_Hour = 8'h00, Set_Minute = 8'h00, Set_Second = 8'h00;
   logic       Set_Ack, Set_Err, Set_Done, Time_Valid, Busy, Timeout_Err;
   logic [7:0] Time_Hour, Time_Minute, Time_Second;

   rtc_cmd_scheduler_if eng_bus();

   rtc_cmd_scheduler #(
      .POLL_CYCLES(POLL), .INIT_ENABLE(1'b1), .INIT_HOUR(8'h12), .INIT_MINUTE(8'h22),
      .INIT_SECOND(8'h22), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(CLK), .RST(RST), .Set_Req(Set_Req), .Set_Hour(Set_Hour), .Set_Minute(Set_Minute),
      .Set_Second(Set_Second), .Set_Ack(Set_Ack), .Set_Err(Set_Err), .Set_Done(Set_Done),
      .Time_Hour(Time_Hour), .Time_Minute(Time_Minute), .Time_Second(Time_Second),
      .Time_Valid(Time_Valid), .Busy(Busy), .Timeout_Err(Timeout_Err), .eng(eng_bus)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   typedef struct { logic [7:0] st; logic [7:0] wd; bit chk_wd; bit chk_gap; } cmd_t;
   typedef struct { logic [7:0] h; logic [7:0] m; logic [7:0] s; } snap_t;
   cmd_t  cmd_q[$];
   snap_t snap_q[$];

   // Engine BFM: Done BFM_LAT cycles after a strobe, register file updated by writes
   logic [7:0] bfm_hr = 8'h00, bfm_min = 8'h00, bfm_sec = 8'h00;
   bit         bfm_sec_force = 1'b0;
   bit         bfm_hang_rdm = 1'b0;
   int         bfm_cnt = 0;
   always @(posedge CLK) begin
      eng_bus.Done_Sig <= 1'b0;
      if (RST || eng_bus.Start_Sig == 8'h00 || eng_bus.Done_Sig) begin
         bfm_cnt <= 0;
      end else if (bfm_hang_rdm && eng_bus.Start_Sig == 8'h02) begin
         bfm_cnt <= 0;
      end else if (bfm_cnt == BFM_LAT - 1) begin
         eng_bus.Done_Sig <= 1'b1;
         bfm_cnt <= 0;
         case (eng_bus.Start_Sig)
            8'h01: eng_bus.Time_Read_Data <= bfm_sec_force ? 8'hA5 : bfm_sec;
            8'h02: eng_bus.Time_Read_Data <= bfm_min;
            8'h04: eng_bus.Time_Read_Data <= bfm_hr;
            8'h40: bfm_hr  <= eng_bus.Time_Write_Data;
            8'h20: bfm_min <= eng_bus.Time_Write_Data;
            8'h10: bfm_sec <= eng_bus.Time_Write_Data;
            default: eng_bus.Time_Read_Data <= 8'h00;
         endcase
      end else begin
         bfm_cnt <= bfm_cnt + 1;
      end
   end

   // Monitor: checks each new command and each snapshot against the scoreboard
   int cyc = 0, fall_cyc = -100, rise_cyc = 0, last_len = 0;
   int valid_cnt = 0, last_valid_cyc = 0, done_cnt = 0, tmo_cnt = 0;
   logic [7:0] prev_st = 8'h00;
   cmd_t  mon_c;
   snap_t mon_s;
   always @(negedge CLK) begin
      cyc++;
      if (eng_bus.Start_Sig != 8'h00 && prev_st == 8'h00) begin
         rise_cyc = cyc;
         vectors++;
         if (cmd_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_cmd: Start_Sig=%h with nothing expected", eng_bus.Start_Sig);
         end else begin
            mon_c = cmd_q.pop_front();
            if (eng_bus.Start_Sig !== mon_c.st || (mon_c.chk_wd && eng_bus.Time_Write_Data !== mon_c.wd)) begin
               miscompares++;
               $display("FAIL cmd: got start=%h data=%h, expected start=%h data=%h",
                        eng_bus.Start_Sig, eng_bus.Time_Write_Data, mon_c.st, mon_c.wd);
            end
            if (mon_c.chk_gap) begin
               vectors++;
               if (cyc - fall_cyc != 1) begin
                  miscompares++;
                  $display("FAIL cmd_gap: start=%h idle cycles=%0d, expected 1", mon_c.st, cyc - fall_cyc - 1);
               end
            end
         end
      end else if (eng_bus.Start_Sig != 8'h00 && eng_bus.Start_Sig !== prev_st) begin
         vectors++;
         miscompares++;
         $display("FAIL cmd_hold: Start_Sig changed %h -> %h without idle", prev_st, eng_bus.Start_Sig);
      end
      if (eng_bus.Start_Sig == 8'h00 && prev_st != 8'h00) begin
         fall_cyc = cyc;
         last_len = cyc - rise_cyc;
      end
      if (Time_Valid) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         vectors++;
         if (snap_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_valid: %h:%h:%h", Time_Hour, Time_Minute, Time_Second);
         end else begin
            mon_s = snap_q.pop_front();
            if (Time_Hour !== mon_s.h || Time_Minute !== mon_s.m || Time_Second !== mon_s.s) begin
               miscompares++;
               $display("FAIL snapshot: got %h:%h:%h, expected %h:%h:%h", Time_Hour, Time_Minute,
                        Time_Second, mon_s.h, mon_s.m, mon_s.s);
            end
         end
      end
      if (Set_Done) done_cnt++;
      if (Timeout_Err) tmo_cnt++;
      prev_st = eng_bus.Start_Sig;
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic push_writes(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      cmd_q.push_back('{8'h80, 8'h00, 1'b1, 1'b0});
      cmd_q.push_back('{8'h40, h, 1'b1, 1'b1});
      cmd_q.push_back('{8'h20, m, 1'b1, 1'b1});
      cmd_q.push_back('{8'h10, s, 1'b1, 1'b1});
   endtask

   task automatic push_reads(input bit gap_first, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      cmd_q.push_back('{8'h01, 8'h00, 1'b0, gap_first});
      cmd_q.push_back('{8'h02, 8'h00, 1'b0, 1'b1});
      cmd_q.push_back('{8'h04, 8'h00, 1'b0, 1'b1});
      snap_q.push_back('{h, m, s});
   endtask

   task automatic wait_valid(input int prev, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         step();
         ok = (valid_cnt > prev);
      end
   endtask

   task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         output bit acked, output bit err);
      acked = 1'b0;
      err = 1'b0;
      Set_Hour = h; Set_Minute = m; Set_Second = s;
      Set_Req = 1'b1;
      for (int i = 0; i < 2000 && !acked; i++) begin
         step();
         if (Set_Ack) begin
            acked = 1'b1;
            err = Set_Err;
         end
      end
      Set_Req = 1'b0;
   endtask

   task automatic test_reset();
      push_writes(8'h12, 8'h22, 8'h22);
      push_reads(1'b1, 8'h12, 8'h22, 8'h22);
      RST = 1'b1;
      repeat (3) step();
      vectors++;
      if (eng_bus.Start_Sig !== 8'h00 || Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ctrl: Start_Sig=%h Busy=%b, expected 00/1", eng_bus.Start_Sig, Busy);
      end
      vectors++;
      if ({Time_Hour, Time_Minute, Time_Second} !== 24'h000000 ||
          {Set_Ack, Set_Err, Set_Done, Time_Valid, Timeout_Err} !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_out: time=%h%h%h flags=%b, expected zeros", Time_Hour, Time_Minute,
                  Time_Second, {Set_Ack, Set_Err, Set_Done, Time_Valid, Timeout_Err});
      end
   endtask

   task automatic test_init();
      bit ok;
      RST = 1'b0;
      wait_valid(valid_cnt, 1000, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL init_valid: no Time_Valid, expected one"); end
      repeat (2) step();
      vectors++;
      if (Busy !== 1'b0 || done_cnt != 0 || valid_cnt != 1 || cmd_q.size() != 0) begin
         miscompares++;
         $display("FAIL init_end: Busy=%b done=%0d valids=%0d left=%0d, expected 0/0/1/0",
                  Busy, done_cnt, valid_cnt, cmd_q.size());
      end
   endtask

   task automatic test_poll();
      bit ok;
      int ta;
      push_reads(1'b0, 8'h12, 8'h22, 8'h22);
      wait_valid(valid_cnt, 1500, ok);
      ta = last_valid_cyc;
      push_reads(1'b0, 8'h12, 8'h22, 8'h22);
      wait_valid(valid_cnt, 1500, ok);
      vectors++;
      if (!ok || last_valid_cyc - ta != POLL) begin
         miscompares++;
         $display("FAIL poll_period: ok=%b period=%0d, expected %0d", ok, last_valid_cyc - ta, POLL);
      end
   endtask

   task automatic test_set_valid();
      bit acked, err, ok;
      int d0 = done_cnt;
      push_writes(8'h23, 8'h59, 8'h58);
      push_reads(1'b1, 8'h23, 8'h59, 8'h58);
      do_set(8'h23, 8'h59, 8'h58, acked, err);
      vectors++;
      if (!acked || err) begin miscompares++; $display("FAIL set_ack: ack=%b err=%b, expected 1/0", acked, err); end
      wait_valid(valid_cnt, 1000, ok);
      vectors++;
      if (!ok || done_cnt != d0 + 1 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL set_done: ok=%b done=%0d Busy=%b, expected 1/%0d/0", ok, done_cnt - d0, Busy, 1);
      end
   endtask

   task automatic test_set_invalid();
      bit acked, err;
      do_set(8'h24, 8'h00, 8'h00, acked, err);
      vectors++;
      if (!acked || !err) begin miscompares++; $display("FAIL bad_hour: ack=%b err=%b, expected 1/1", acked, err); end
      step();
      do_set(8'h00, 8'h00, 8'h5A, acked, err);
      vectors++;
      if (!acked || !err) begin miscompares++; $display("FAIL bad_second: ack=%b err=%b, expected 1/1", acked, err); end
      repeat (5) step();
      vectors++;
      if (Busy !== 1'b0 || eng_bus.Start_Sig !== 8'h00) begin
         miscompares++;
         $display("FAIL bad_no_cmd: Busy=%b Start_Sig=%h, expected 0/00", Busy, eng_bus.Start_Sig);
      end
   endtask

   task automatic test_set_during_read();
      bit acked, err, ok;
      int v0;
      push_reads(1'b0, 8'h23, 8'h59, 8'h58);
      ok = 1'b0;
      for (int i = 0; i < 1500 && !ok; i++) begin
         step();
         ok = (eng_bus.Start_Sig == 8'h01);
      end
      v0 = valid_cnt;
      push_writes(8'h01, 8'h02, 8'h03);
      push_reads(1'b1, 8'h01, 8'h02, 8'h03);
      do_set(8'h01, 8'h02, 8'h03, acked, err);
      vectors++;
      if (!ok || !acked || err || valid_cnt != v0 + 1) begin
         miscompares++;
         $display("FAIL set_vs_read: seen=%b ack=%b err=%b valids=%0d, expected 1/1/0/1", ok, acked, err, valid_cnt - v0);
      end
      wait_valid(valid_cnt, 1000, ok);
   endtask

   task automatic test_tick_during_set();
      bit acked, err, ok;
      int v1;
      push_reads(1'b0, 8'h01, 8'h02, 8'h03);
      wait_valid(valid_cnt, 1500, ok);
      repeat (780) step();
      push_writes(8'h04, 8'h05, 8'h06);
      push_reads(1'b1, 8'h04, 8'h05, 8'h06);
      do_set(8'h04, 8'h05, 8'h06, acked, err);
      wait_valid(valid_cnt, 1000, ok);
      v1 = valid_cnt;
      repeat (600) step();
      vectors++;
      if (!ok || valid_cnt != v1 || cmd_q.size() != 0) begin
         miscompares++;
         $display("FAIL tick_collapse: ok=%b extra valids=%0d left=%0d, expected 1/0/0", ok, valid_cnt - v1, cmd_q.size());
      end
   endtask

   task automatic test_read_mask();
      bit ok;
      bfm_sec_force = 1'b1;
      push_reads(1'b0, 8'h04, 8'h05, 8'h25);
      wait_valid(valid_cnt, 1500, ok);
      bfm_sec_force = 1'b0;
      vectors++;
      if (!ok || Time_Second !== 8'h25) begin
         miscompares++;
         $display("FAIL sec_mask: ok=%b Time_Second=%h, expected 25", ok, Time_Second);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int t0 = tmo_cnt;
      int v0 = valid_cnt;
      bfm_hang_rdm = 1'b1;
      cmd_q.push_back('{8'h01, 8'h00, 1'b0, 1'b0});
      cmd_q.push_back('{8'h02, 8'h00, 1'b0, 1'b1});
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         step();
         ok = (tmo_cnt > t0);
      end
      bfm_hang_rdm = 1'b0;
      vectors++;
      if (!ok || last_len != TMO || eng_bus.Start_Sig !== 8'h00 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout: ok=%b held=%0d Start=%h Busy=%b, expected 1/%0d/00/0", ok, last_len,
                  eng_bus.Start_Sig, Busy, TMO);
      end
      vectors++;
      if ({Time_Hour, Time_Minute, Time_Second} !== 24'h040525 || valid_cnt != v0) begin
         miscompares++;
         $display("FAIL timeout_snap: %h:%h:%h valids=%0d, expected 04:05:25 and 0 new", Time_Hour,
                  Time_Minute, Time_Second, valid_cnt - v0);
      end
   endtask

   task automatic test_reset_mid_set();
      bit acked, err, ok;
      int d0;
      cmd_q.push_back('{8'h80, 8'h00, 1'b1, 1'b0});
      cmd_q.push_back('{8'h40, 8'h10, 1'b1, 1'b1});
      do_set(8'h10, 8'h20, 8'h30, acked, err);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         step();
         ok = (eng_bus.Start_Sig == 8'h40);
      end
      repeat (5) step();
      d0 = done_cnt;
      RST = 1'b1;
      step();
      vectors++;
      if (!acked || !ok || eng_bus.Start_Sig !== 8'h00 || Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid: ack=%b inSET_H=%b Start=%h Busy=%b, expected 1/1/00/1", acked, ok,
                  eng_bus.Start_Sig, Busy);
      end
      push_writes(8'h12, 8'h22, 8'h22);
      push_reads(1'b1, 8'h12, 8'h22, 8'h22);
      step();
      RST = 1'b0;
      wait_valid(valid_cnt, 1000, ok);
      step();
      vectors++;
      if (!ok || done_cnt != d0 || cmd_q.size() != 0 || snap_q.size() != 0) begin
         miscompares++;
         $display("FAIL reinit: ok=%b Set_Done=%0d left=%0d/%0d, expected 1/0/0/0", ok, done_cnt - d0,
                  cmd_q.size(), snap_q.size());
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init();
      test_poll();
      test_set_valid();
      test_set_invalid();
      test_set_during_read();
      test_tick_during_set();
      test_read_mask();
      test_timeout();
      test_reset_mid_set();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
